// File: rtl/deint_frame_sync.sv
// deint_frame_sync: HUNT/VERIFY/LOCK frame aligner for de-interleaved 12-bit words.
// Define FRAME_SYNC_INV_EN to also acquire and track an inverted sync pattern.
module deint_frame_sync #(
    parameter logic [11:0] SYNC_WORD = 12'hB8F,
    parameter int          FRAME_LEN = 136,
    parameter int          LOCK_CNT  = 3,
    parameter int          LOSS_CNT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] din,
    input  logic        din_valid,
    output logic [11:0] dout,
    output logic        dout_valid,
    output logic        dout_sof,
    output logic        locked,
    output logic [1:0]  state,
    output logic [15:0] frame_cnt,
    output logic        inv
);
    typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCK = 2'd2} state_t;
    localparam logic [11:0] LAST = 12'(FRAME_LEN - 1);
    state_t      st, st_n;
    logic [11:0] pos, pos_n, dword;
    logic [3:0]  hit_cnt, hit_n, miss_cnt, miss_n;
    logic        inv_q, inv_n, emit, match, hunt_match, hunt_inv;
`ifdef FRAME_SYNC_INV_EN
    logic hit_pos, hit_neg;
    assign hit_pos    = din == SYNC_WORD;
    assign hit_neg    = din == ~SYNC_WORD;
    assign match      = inv_q ? hit_neg : hit_pos;
    assign hunt_match = hit_pos | hit_neg;
    assign hunt_inv   = !hit_pos;
    assign dword      = inv_q ? ~din : din;
`else
    assign match      = din == SYNC_WORD;
    assign hunt_match = match;
    assign hunt_inv   = 1'b0;
    assign dword      = din;
`endif
    assign state = st;
    assign inv   = inv_q;
    always_comb begin
        st_n   = st;
        pos_n  = pos;
        hit_n  = hit_cnt;
        miss_n = miss_cnt;
        inv_n  = inv_q;
        emit   = 1'b0;
        if (din_valid) begin
            pos_n = pos == LAST ? 12'd0 : pos + 12'd1;
            case (st)
                HUNT: if (hunt_match) begin
                    st_n  = VERIFY;
                    pos_n = 12'd1;
                    hit_n = 4'd1;
                    inv_n = hunt_inv;
                end
                VERIFY: if (pos == 12'd0) begin
                    if (match) begin
                        hit_n = hit_cnt + 4'd1;
                        if (hit_cnt + 4'd1 == 4'(LOCK_CNT)) begin
                            st_n   = LOCK;
                            miss_n = 4'd0;
                            emit   = 1'b1;
                        end
                    end else begin
                        st_n  = HUNT;
                        hit_n = 4'd0;
                        inv_n = 1'b0;
                    end
                end
                LOCK: begin
                    emit = 1'b1;
                    // flywheel through isolated misses; only a run of LOSS_CNT drops lock
                    if (pos == 12'd0) begin
                        miss_n = match ? 4'd0 : miss_cnt + 4'd1;
                        if (!match && miss_cnt + 4'd1 == 4'(LOSS_CNT)) begin
                            st_n   = HUNT;
                            miss_n = 4'd0;
                            hit_n  = 4'd0;
                            inv_n  = 1'b0;
                            emit   = 1'b0;
                        end
                    end
                end
                default: st_n = HUNT;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= HUNT;
            pos        <= 12'd0;
            hit_cnt    <= 4'd0;
            miss_cnt   <= 4'd0;
            inv_q      <= 1'b0;
            dout       <= 12'd0;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            locked     <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            st         <= st_n;
            pos        <= pos_n;
            hit_cnt    <= hit_n;
            miss_cnt   <= miss_n;
            inv_q      <= inv_n;
            dout       <= emit ? dword : dout;
            dout_valid <= emit;
            dout_sof   <= emit && pos == 12'd0;
            locked     <= st_n == LOCK;
            frame_cnt  <= frame_cnt + {15'd0, emit && pos == 12'd0};
        end
    end
endmodule

// File: doc/deint_frame_sync.md
DEINT_FRAME_SYNC -- requirements
Module: deint_frame_sync

Interface
REQ-001 Parameter SYNC_WORD, default 12'hB8F, 12-bit frame sync pattern at frame word 0.
REQ-002 Parameter FRAME_LEN, default 136, words per frame including sync word; legal range 2..4095.
REQ-003 Parameter LOCK_CNT, default 3, consecutive sync hits needed to declare lock; legal range 2..15.
REQ-004 Parameter LOSS_CNT, default 2, consecutive sync misses in lock needed to drop lock; legal range 1..15.
REQ-005 clk  input  1  single clock, all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 din  input  12  de-interleaved word from upstream de-interleaver output Q.
REQ-008 din_valid  input  1  din qualifier; one word accepted per clk with din_valid=1.
REQ-009 dout  output  12  frame-aligned word, registered.
REQ-010 dout_valid  output  1  dout qualifier, one-cycle pulse per emitted word.
REQ-011 dout_sof  output  1  high with dout_valid when dout is frame word 0.
REQ-012 locked  output  1  high while state is LOCK.
REQ-013 state  output  2  current FSM state: 0 HUNT, 1 VERIFY, 2 LOCK.
REQ-014 frame_cnt  output  16  count of emitted sof words.
REQ-015 inv  output  1  sync polarity in use (1 = inverted sync tracked).

Function
REQ-016 Word position counter pos, 12 bits, SHALL advance only on accepted words: pos=FRAME_LEN-1 wraps to 0; pos=0 is the sync slot.
REQ-017 din_valid=0 SHALL freeze pos, FSM, counters; dout_valid and dout_sof SHALL be 0 the next cycle, dout holds.
REQ-018 HUNT: every accepted word compared to sync; match -> VERIFY, pos set so the next word is position 1, hit_cnt=1; no match -> stay HUNT.
REQ-019 VERIFY: on accepted word at pos 0, match -> hit_cnt+1, hit_cnt reaching LOCK_CNT -> LOCK; mismatch -> HUNT, hit_cnt=0; words at pos!=0 not checked.
REQ-020 LOCK: at pos 0, match -> miss_cnt=0; mismatch -> miss_cnt+1; miss_cnt reaching LOSS_CNT -> HUNT with miss_cnt=0, else stay LOCK (flywheel).
REQ-021 Word accepted in LOCK, or the sync word causing VERIFY->LOCK, SHALL appear on dout with dout_valid=1 exactly one clk later; the word causing LOCK->HUNT SHALL NOT be emitted.
REQ-022 dout_sof=1 exactly for emitted pos-0 words, including flywheeled (mismatched) pos-0 words in LOCK.
REQ-023 frame_cnt SHALL increment by 1 per emitted sof word, wrapping 16'hFFFF -> 0; not cleared on lock loss.
REQ-024 locked and state SHALL be registered, changing in the same cycle dout_valid reflects the transition word.
REQ-025 Sync match and pos wrap on the same word SHALL be evaluated using pre-update pos (sync slot = pos 0 before increment).

Reset
REQ-026 rst_n=0 SHALL immediately force: state=HUNT, pos=0, hit_cnt=0, miss_cnt=0, dout=0, dout_valid=0, dout_sof=0, locked=0, frame_cnt=0, inv=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release, lock reacquisition starts from HUNT with no residual output.

Configuration
REQ-028 Macro FRAME_SYNC_INV_EN defined: HUNT also matches ~SYNC_WORD; polarity of first hit latched into inv; VERIFY/LOCK checks require that polarity; dout = ~din when inv=1; inv cleared on return to HUNT.
REQ-029 Macro FRAME_SYNC_INV_EN undefined: only SYNC_WORD matches, inv tied 0, dout = din.

Verification (bench params FRAME_LEN=8, LOCK_CNT=3, LOSS_CNT=2, SYNC_WORD=12'hB8F)
REQ-030 Three frames, words 12'hB8F,1..7 continuous valid -> locked=1 after 3rd sync; first dout_valid is that 12'hB8F with dout_sof=1, one clk later; frame_cnt=1.
REQ-031 Locked stream, one frame's sync replaced by 12'h000 -> stays LOCK, that word emitted with dout_sof=1; two consecutive corrupted syncs -> HUNT on 2nd, 2nd not emitted, locked=0.
REQ-032 Sync then 12'h123 at next pos 0 -> VERIFY->HUNT, no dout_valid ever.
REQ-033 Locked stream with din_valid toggling 1,0,1,0 -> pos advances only on valid words; dout_valid pulses match accepted words 1 clk later; sof alignment preserved.
REQ-034 rst_n low for 1 clk mid-frame in LOCK -> all outputs 0 asynchronously; clean relock after 3 further frames.
REQ-035 FRAME_SYNC_INV_EN defined, stream with sync 12'h470 -> inv=1, lock after 3 frames, dout = ~din (word 12'h001 -> 12'hFFE).
